// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_hazard_ctrl_pkg: shared select codes, register width and tracking-slot record
package fwd_hazard_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_SEL_RF  = 2'b00;
    localparam logic [1:0] FWD_SEL_MEM = 2'b01;
    localparam logic [1:0] FWD_SEL_WB  = 2'b10;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              reg_write;
        logic              mem_read;
    } slot_t;
    // a slot forwards only a real, register-writing producer of a nonzero register
    function automatic logic fwd_hit(slot_t s, logic [REG_AW-1:0] r);
        return s.valid && s.reg_write && s.dst != '0 && s.dst == r;
    endfunction
endpackage

// File: rtl/fwd_track_slot.sv
// fwd_track_slot: one pipeline tracking slot with async reset, load enable and bubble insert
module fwd_track_slot
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  en_i,
    input  logic  bubble_i,
    input  slot_t d_i,
    output slot_t q_o
);
    slot_t slot_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) slot_q <= '0;
        else if (en_i) slot_q <= bubble_i ? '0 : d_i;
    end
    assign q_o = slot_q;
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX-operand forwarding selects and load-use stall for the 5-stage pipeline
// Define FWD_STALL_CNT_EN to add the saturating stall_cnt output.
module fwd_hazard_ctrl #(
    parameter int REG_AW = fwd_hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);
    import fwd_hazard_ctrl_pkg::*;

    slot_t ex_q, mem_q, wb_unused_q, id_slot;
    logic take;
    logic [1:0] fwd_a_d, fwd_b_d, fwd_a_q, fwd_b_q;

    assign id_slot = '{valid: 1'b1, dst: id_dst, reg_write: id_reg_write, mem_read: id_mem_read};
    assign stall = id_valid && !flush && ex_q.valid && ex_q.mem_read && ex_q.dst != '0
                   && (ex_q.dst == id_rs || ex_q.dst == id_rt);
    assign take = id_valid && !stall && !flush;

    fwd_track_slot u_ex  (.clk(clk), .reset(reset), .en_i(1'b1), .bubble_i(!take), .d_i(id_slot), .q_o(ex_q));
    fwd_track_slot u_mem (.clk(clk), .reset(reset), .en_i(1'b1), .bubble_i(1'b0),  .d_i(ex_q),    .q_o(mem_q));
    // WB only ages out; write-before-read in the register file covers WB-to-ID
    fwd_track_slot u_wb  (.clk(clk), .reset(reset), .en_i(1'b1), .bubble_i(1'b0),  .d_i(mem_q),   .q_o(wb_unused_q));

    always_comb begin
        fwd_a_d = !take ? FWD_SEL_RF : fwd_hit(ex_q, id_rs) ? FWD_SEL_MEM
                : fwd_hit(mem_q, id_rs) ? FWD_SEL_WB : FWD_SEL_RF;
        fwd_b_d = !take ? FWD_SEL_RF : fwd_hit(ex_q, id_rt) ? FWD_SEL_MEM
                : fwd_hit(mem_q, id_rt) ? FWD_SEL_WB : FWD_SEL_RF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fwd_a_q <= FWD_SEL_RF;
            fwd_b_q <= FWD_SEL_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    assign stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else stall_cnt_q <= stall_cnt_d;
    end
    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed vector table, reset corner case and random run against a pipeline model
module tb_fwd_hazard_ctrl;
    logic       clk = 1'b0;
    logic       reset, id_valid, id_reg_write, id_mem_read, flush, stall;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    fwd_hazard_ctrl #(.REG_AW(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
`ifdef FWD_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic chk(string nm, logic [31:0] act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB, as plain instruction records
    typedef struct { bit v; int dst; bit rw; bit mr; } rec_t;
    rec_t pipe[3];
    int m_a, m_b, m_cnt;

    function automatic int m_stall();
        if (!id_valid || flush || !pipe[0].v || !pipe[0].mr || pipe[0].dst == 0) return 0;
        return (pipe[0].dst == int'(id_rs) || pipe[0].dst == int'(id_rt)) ? 1 : 0;
    endfunction

    function automatic int m_sel(int r);
        for (int k = 0; k < 2; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].dst != 0 && pipe[k].dst == r) return k + 1;
        return 0;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{0, 0, 0, 0};
        m_a = 0; m_b = 0; m_cnt = 0;
    endtask

    task automatic m_clock();
        int s;
        bit take;
        s = m_stall();
        take = id_valid && s == 0 && !flush;
        m_a = take ? m_sel(int'(id_rs)) : 0;
        m_b = take ? m_sel(int'(id_rt)) : 0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = take ? '{1, int'(id_dst), id_reg_write, id_mem_read} : '{0, 0, 0, 0};
        if (s != 0 && m_cnt < 65535) m_cnt++;
    endtask

    task automatic drive(bit v, int rs, int rt, int dst, bit rw, bit mr, bit fl);
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_dst = 5'(dst);
        id_reg_write = rw; id_mem_read = mr; flush = fl;
    endtask

    typedef struct { bit v; int rs; int rt; int dst; bit rw; bit mr; bit fl; int s; int a; int b; } vec_t;
    vec_t vecs[18];

    initial begin
        vecs = '{
            '{1,1,2,3,1,0,0, 0,0,0},   // add $3
            '{0,0,0,0,0,0,0, 0,0,0},   // nop
            '{1,1,3,4,1,0,0, 0,0,2},   // rt=$3 two back -> WB
            '{1,1,2,3,1,0,0, 0,0,0},   // add $3
            '{1,0,0,3,1,0,0, 0,0,0},   // add $3 again
            '{1,3,3,9,1,0,0, 0,1,1},   // nearest producer wins
            '{1,1,2,5,1,1,0, 0,0,0},   // lw $5
            '{1,5,6,10,1,0,0, 1,0,0},  // load-use stall
            '{1,5,6,10,1,0,0, 0,2,0},  // re-presented -> WB
            '{1,1,2,0,1,1,0, 0,0,0},   // load into $0
            '{1,0,0,11,1,0,0, 0,0,0},  // read $0
            '{1,1,2,7,1,1,0, 0,0,0},   // lw $7
            '{1,7,7,12,1,0,1, 0,0,0},  // load-use with flush
            '{1,7,2,12,1,0,0, 0,2,0},  // lw $7 now in MEM
            '{1,1,2,8,1,1,0, 0,0,0},   // lw $8
            '{1,1,2,8,1,1,0, 0,0,0},   // lw $8 again
            '{1,8,8,13,1,0,0, 1,0,0},  // stall on nearest load
            '{1,8,8,13,1,0,0, 0,2,2}   // both from nearest load
        };
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_a", fwd_a_sel, 0);
        chk("reset_b", fwd_b_sel, 0);
`ifdef FWD_STALL_CNT_EN
        chk("reset_cnt", stall_cnt, 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].dst, vecs[i].rw, vecs[i].mr, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].s);
            m_clock();
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_a", i), fwd_a_sel, vecs[i].a);
            chk($sformatf("vec%0d_b", i), fwd_b_sel, vecs[i].b);
        end
`ifdef FWD_STALL_CNT_EN
        chk("table_cnt", stall_cnt, 2);
`endif

        // async reset while a load-use stall is pending
        drive(1, 1, 2, 5, 1, 1, 0);
        m_clock();
        @(posedge clk);
        #1;
        drive(1, 5, 5, 6, 1, 0, 0);
        #1;
        chk("pre_reset_stall", stall, 1);
        reset = 1'b1;
        #1;
        m_reset();
        chk("mid_reset_stall", stall, 0);
        chk("mid_reset_a", fwd_a_sel, 0);
        chk("mid_reset_b", fwd_b_sel, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("post_reset_stall", stall, 0);
        m_clock();
        @(posedge clk);
        #1;
        chk("post_reset_a", fwd_a_sel, 0);
`ifdef FWD_STALL_CNT_EN
        chk("post_reset_cnt", stall_cnt, 0);
`endif

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                m_reset();
                chk("rnd_reset_a", fwd_a_sel, 0);
                chk("rnd_reset_stall", stall, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) == 0);
            #1;
            chk("rnd_stall", stall, m_stall());
            chk("rnd_a", fwd_a_sel, m_a);
            chk("rnd_b", fwd_b_sel, m_b);
`ifdef FWD_STALL_CNT_EN
            chk("rnd_cnt", stall_cnt, m_cnt);
`endif
            m_clock();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
